// File: rtl/hp300_ioctl_pkg.sv
// Shared types and constants for the hp300 ioctl upload/download paths.
package hp300_ioctl_pkg;

  // Upload responder state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PREF  = 2'd2
  } ioctl_state_e;

  localparam int          IOCTL_DW          = 16;
  localparam logic [15:0] IDX_ROM_DOWNLOAD  = 16'h0001;
  localparam logic [15:0] IDX_NVRAM_UPLOAD  = 16'h0002;
  localparam logic [15:0] FILL_DEFAULT      = 16'hFFFF;

endpackage

// File: rtl/hp300_ioctl_prefetch.sv
// Single-entry prefetch buffer: one tagged word with a valid bit and hit compare.
module hp300_ioctl_prefetch
  import hp300_ioctl_pkg::*;
#(
  parameter int TAG_W = 26
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                inv_i,
  input  logic                wr_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [IOCTL_DW-1:0] wr_data_i,
  input  logic [TAG_W-1:0]    lk_tag_i,
  output logic                hit_o,
  output logic [IOCTL_DW-1:0] data_o
);

  logic                valid;
  logic [TAG_W-1:0]    tag;
  logic [IOCTL_DW-1:0] data;

  // Valid bit: invalidation wins over a simultaneous fill
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  valid <= 1'b0;
    else if (inv_i)  valid <= 1'b0;
    else if (wr_i)   valid <= 1'b1;
  end

  // Tag and data are only meaningful while valid, so they carry no reset
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      tag  <= wr_tag_i;
      data <= wr_data_i;
    end
  end

  assign hit_o  = valid && (tag == lk_tag_i);
  assign data_o = data;

endmodule

// File: rtl/hp300_ioctl_upload.sv
// HPS upload responder: serves ioctl reads from a memory read port with a
// one-word sequential prefetch so linear uploads rarely stall.
module hp300_ioctl_upload
  import hp300_ioctl_pkg::*;
#(
  parameter int                MEM_AW      = 22,
  parameter logic [MEM_AW-1:0] BASE_WORD   = '0,
  parameter logic [22:0]       IMAGE_WORDS = 23'h200000,
  parameter logic [15:0]       INDEX       = IDX_NVRAM_UPLOAD,
  parameter logic [15:0]       FILL        = FILL_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ioctl_upload_i,
  input  logic [15:0]       ioctl_index_i,
  input  logic              ioctl_read_i,
  input  logic [26:0]       ioctl_addr_i,
  output logic [15:0]       ioctl_data_o,
  output logic              ioctl_wait_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [15:0]       mem_data_i
);

  function automatic logic [MEM_AW-1:0] mem_word(input logic [25:0] ww);
    return BASE_WORD + MEM_AW'(ww);
  endfunction

  function automatic logic in_img(input logic [26:0] x);
    return x < 27'(IMAGE_WORDS);
  endfunction

  ioctl_state_e state;
  logic         busy, pend, upl_d, discard;
  logic [25:0]  pend_w, cur_w, pref_w;

  logic         rd_srv, upl_fall, discard_now;
  logic         res_go, res_in, res_nx_in, cur_nx_in;
  logic [25:0]  req_w, res_w;
  logic [26:0]  res_nx, cur_nx;
  logic         pf_hit, pf_inv, pf_wr;
  logic [15:0]  pf_data;
  logic         addr_lsb_unused;

  assign addr_lsb_unused = ioctl_addr_i[0];

  assign rd_srv      = ioctl_read_i && ioctl_upload_i && (ioctl_index_i == INDEX);
  assign req_w       = ioctl_addr_i[26:1];
  assign upl_fall    = upl_d && !ioctl_upload_i;
  assign discard_now = discard || upl_fall;

  // A read latched during a prefetch is resolved ahead of any new strobe
  assign res_w     = pend ? pend_w : req_w;
  assign res_go    = (state == ST_IDLE) && (pend || rd_srv);
  assign res_in    = in_img({1'b0, res_w});
  assign res_nx    = {1'b0, res_w} + 27'd1;
  assign res_nx_in = in_img(res_nx);
  assign cur_nx    = {1'b0, cur_w} + 27'd1;
  assign cur_nx_in = in_img(cur_nx);

  assign pf_inv = upl_fall || (res_go && res_in && !pf_hit);
  assign pf_wr  = (state == ST_PREF) && mem_ack_i && !discard_now;

  hp300_ioctl_prefetch #(.TAG_W(26)) u_prefetch (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inv_i     (pf_inv),
    .wr_i      (pf_wr),
    .wr_tag_i  (pref_w),
    .wr_data_i (mem_data_i),
    .lk_tag_i  (res_w),
    .hit_o     (pf_hit),
    .data_o    (pf_data)
  );

  assign ioctl_wait_o = reset_n_i && (busy || rd_srv);

  // Request FSM: demand fetch, prefetch, and registered ioctl/memory outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      pend         <= 1'b0;
      upl_d        <= 1'b0;
      discard      <= 1'b0;
      pend_w       <= '0;
      cur_w        <= '0;
      pref_w       <= '0;
      ioctl_data_o <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
    end else begin
      upl_d <= ioctl_upload_i;
      if (upl_fall && (state != ST_IDLE)) discard <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (res_go) begin
            pend <= 1'b0;
            if (!res_in) begin
              ioctl_data_o <= FILL;
              busy         <= 1'b0;
            end else if (pf_hit) begin
              ioctl_data_o <= pf_data;
              busy         <= 1'b0;
              if (res_nx_in) begin
                state      <= ST_PREF;
                mem_req_o  <= 1'b1;
                mem_addr_o <= mem_word(res_nx[25:0]);
                pref_w     <= res_nx[25:0];
              end
            end else begin
              state      <= ST_FETCH;
              busy       <= 1'b1;
              mem_req_o  <= 1'b1;
              mem_addr_o <= mem_word(res_w);
              cur_w      <= res_w;
            end
          end
        end
        ST_FETCH: begin
          if (mem_ack_i) begin
            busy    <= 1'b0;
            discard <= 1'b0;
            if (!discard_now) ioctl_data_o <= mem_data_i;
            if (!discard_now && cur_nx_in) begin
              state      <= ST_PREF;
              mem_addr_o <= mem_word(cur_nx[25:0]);
              pref_w     <= cur_nx[25:0];
            end else begin
              state     <= ST_IDLE;
              mem_req_o <= 1'b0;
            end
          end else if (upl_fall) begin
            busy <= 1'b0;
          end
        end
        ST_PREF: begin
          if (rd_srv && !pend) begin
            pend   <= 1'b1;
            pend_w <= req_w;
            busy   <= 1'b1;
          end
          if (mem_ack_i) begin
            state     <= ST_IDLE;
            mem_req_o <= 1'b0;
            discard   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hp300_ioctl_upload.sv
// Directed bench for hp300_ioctl_upload with a fixed-latency memory model.
module tb_hp300_ioctl_upload;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        ioctl_upload_i = 1'b0;
  logic [15:0] ioctl_index_i = 16'h0;
  logic        ioctl_read_i = 1'b0;
  logic [26:0] ioctl_addr_i = '0;
  logic [15:0] ioctl_data_o;
  logic        ioctl_wait_o;
  logic        mem_req_o;
  logic [21:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_data_i = 16'h0;

  hp300_ioctl_upload dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .ioctl_upload_i (ioctl_upload_i),
    .ioctl_index_i  (ioctl_index_i),
    .ioctl_read_i   (ioctl_read_i),
    .ioctl_addr_i   (ioctl_addr_i),
    .ioctl_data_o   (ioctl_data_o),
    .ioctl_wait_o   (ioctl_wait_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int lat = 5;
  int cnt = 0;
  logic [21:0] reqq[$];
  logic        req_q = 1'b0;
  logic [21:0] addr_q = '0;

  function automatic logic [15:0] mem_val(input logic [21:0] a);
    if (a == 22'h0) return 16'h1234;
    if (a == 22'h1) return 16'hBEEF;
    return 16'hA000 ^ a[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Memory model: ack after the request has been held for lat cycles
  always @(posedge clk_i) begin
    #1;
    if (!reset_n_i) begin
      mem_ack_i = 1'b0;
      cnt = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      cnt = 0;
    end else if (mem_req_o) begin
      if (cnt == lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_val(mem_addr_o);
      end else begin
        cnt++;
      end
    end
  end

  // Request log: records each new request (rise or address change)
  always @(posedge clk_i) begin
    #2;
    if (mem_req_o && (!req_q || mem_addr_o != addr_q)) reqq.push_back(mem_addr_o);
    req_q  = mem_req_o;
    addr_q = mem_addr_o;
  end

  task automatic do_read(input logic [26:0] a, input logic [15:0] idx, input bit upl,
                         output int wc, output logic [15:0] d);
    @(posedge clk_i); #1;
    ioctl_addr_i   = a;
    ioctl_index_i  = idx;
    ioctl_upload_i = upl;
    ioctl_read_i   = 1'b1;
    reqq.delete();
    wc = 0;
    @(negedge clk_i);
    if (ioctl_wait_o) wc++;
    @(posedge clk_i); #1;
    ioctl_read_i = 1'b0;
    @(negedge clk_i);
    while (ioctl_wait_o && wc < 200) begin
      wc++;
      @(negedge clk_i);
    end
    d = ioctl_data_o;
  endtask

  task automatic settle();
    for (int i = 0; i < 200 && mem_req_o; i++) @(negedge clk_i);
    chk("settle_req_idle", {31'b0, mem_req_o}, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  typedef struct {
    logic [26:0] addr;
    logic [15:0] idx;
    bit          upl;
    logic [15:0] d;
    int          wc;
    int          nreq;
    logic [21:0] a0;
    logic [21:0] a1;
  } vec_t;

  vec_t vt[10];

  initial begin
    int          wc;
    logic [15:0] d;

    #300000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          wc;
    logic [15:0] d;

    vt[0] = '{27'h0000000, 16'h0002, 1'b1, 16'h1234, 7, 2, 22'h000000, 22'h000001};
    vt[1] = '{27'h0000002, 16'h0002, 1'b1, 16'hBEEF, 1, 1, 22'h000002, 22'h0};
    vt[2] = '{27'h0000100, 16'h0002, 1'b1, 16'hA080, 7, 2, 22'h000080, 22'h000081};
    vt[3] = '{27'h0400000, 16'h0002, 1'b1, 16'hFFFF, 1, 0, 22'h0, 22'h0};
    vt[4] = '{27'h0000102, 16'h0001, 1'b1, 16'hFFFF, 0, 0, 22'h0, 22'h0};
    vt[5] = '{27'h0000102, 16'h0002, 1'b1, 16'hA081, 1, 1, 22'h000082, 22'h0};
    vt[6] = '{27'h03FFFFE, 16'h0002, 1'b1, 16'h5FFF, 7, 1, 22'h1FFFFF, 22'h0};
    vt[7] = '{27'h03FFFFC, 16'h0002, 1'b1, 16'h5FFE, 7, 2, 22'h1FFFFE, 22'h1FFFFF};
    vt[8] = '{27'h03FFFFE, 16'h0002, 1'b1, 16'h5FFF, 1, 0, 22'h0, 22'h0};
    vt[9] = '{27'h03FFFFE, 16'h0002, 1'b0, 16'h5FFF, 0, 0, 22'h0, 22'h0};

    // Reset with a served-looking read applied: wait must stay low
    ioctl_upload_i = 1'b1;
    ioctl_index_i  = 16'h0002;
    ioctl_read_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_wait", {31'b0, ioctl_wait_o}, 32'h0);
    chk("rst_data", {16'b0, ioctl_data_o}, 32'h0);
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_addr", {10'b0, mem_addr_o}, 32'h0);
    ioctl_read_i = 1'b0;
    @(posedge clk_i); #3;
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 10; i++) begin
      do_read(vt[i].addr, vt[i].idx, vt[i].upl, wc, d);
      settle();
      chk($sformatf("v%0d_data", i), {16'b0, d}, {16'b0, vt[i].d});
      chk($sformatf("v%0d_wait", i), wc, vt[i].wc);
      chk($sformatf("v%0d_nreq", i), reqq.size(), vt[i].nreq);
      if (vt[i].nreq >= 1 && reqq.size() >= 1)
        chk($sformatf("v%0d_addr0", i), {10'b0, reqq[0]}, {10'b0, vt[i].a0});
      if (vt[i].nreq >= 2 && reqq.size() >= 2)
        chk($sformatf("v%0d_addr1", i), {10'b0, reqq[1]}, {10'b0, vt[i].a1});
    end

    // Read arriving while the word-1 prefetch is still outstanding
    lat = 8;
    do_read(27'h0, 16'h0002, 1'b1, wc, d);
    chk("pend_fetch_wait", wc, 10);
    chk("pend_fetch_data", {16'b0, d}, 32'h1234);
    do_read(27'h2, 16'h0002, 1'b1, wc, d);
    chk("pend_hit_wait", wc, 10);
    chk("pend_hit_data", {16'b0, d}, 32'hBEEF);
    settle();
    chk("pend_hit_nreq", reqq.size(), 1);
    if (reqq.size() >= 1) chk("pend_hit_addr0", {10'b0, reqq[0]}, 32'h2);

    // Reset in the middle of a demand fetch
    lat = 5;
    @(posedge clk_i); #1;
    ioctl_addr_i  = 27'h200;
    ioctl_read_i  = 1'b1;
    @(posedge clk_i); #1;
    ioctl_read_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    chk("midrst_req_before", {31'b0, mem_req_o}, 32'h1);
    reset_n_i = 1'b0;
    #1;
    chk("midrst_req", {31'b0, mem_req_o}, 32'h0);
    chk("midrst_wait", {31'b0, ioctl_wait_o}, 32'h0);
    chk("midrst_data", {16'b0, ioctl_data_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    #3;
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    do_read(27'h0, 16'h0002, 1'b1, wc, d);
    chk("postrst_wait", wc, 7);
    chk("postrst_data", {16'b0, d}, 32'h1234);
    if (reqq.size() >= 1) chk("postrst_addr0", {10'b0, reqq[0]}, 32'h0);
    else chk("postrst_nreq", reqq.size(), 1);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
